// File: rtl/counterup16_sched.sv
// Programmable 16-bit up-counter timer: start/stop/pause/restart, one-shot or periodic,
// terminal tick pulse and sticky irq. Optional prescaler enabled by COUNTERUP16_SCHED_PRESCALE_EN.
module counterup16_sched #(
    parameter int WIDTH = 16
`ifdef COUNTERUP16_SCHED_PRESCALE_EN
    ,
    parameter int PRESCALE_W = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             periodic,
    input  logic [WIDTH-1:0] period,
    input  logic             irq_clr,
`ifdef COUNTERUP16_SCHED_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             irq,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             periodic_q, periodic_d;
    logic             tick_q, tick_d;
    logic             irq_q, irq_d;
    logic             busy_q, busy_d;
    logic             step_en;

`ifdef COUNTERUP16_SCHED_PRESCALE_EN
    logic [PRESCALE_W-1:0] psc_q, psc_d;

    assign step_en = (psc_q == prescale);

    // Prescaler only runs while actively counting; pause and hold freeze it.
    always_comb begin
        psc_d = psc_q;
        if (stop || start) begin
            psc_d = '0;
        end else if (state_q == RUN && !hold) begin
            psc_d = step_en ? '0 : psc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign step_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            tick_q     <= tick_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
        end
    end

    // Priority: stop, then start, then hold, then terminal/increment.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        tick_d     = 1'b0;
        irq_d      = irq_q;

        if (irq_clr) begin
            irq_d = 1'b0;
        end

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            period_d   = period;
            periodic_d = periodic;
            count_d    = '0;
            state_d    = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hold) begin
                        state_d = PAUSE;
                    end else if (step_en) begin
                        if (count_q == period_q) begin
                            tick_d = 1'b1;
                            irq_d  = 1'b1;
                            if (periodic_q) begin
                                count_d = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!hold) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign irq   = irq_q;
    assign busy  = busy_q;
    assign state = state_q;

endmodule

// File: tb/tb_counterup16_sched.sv
// Self-checking bench for counterup16_sched: directed scenarios plus randomized commands
// compared against an arithmetic reference model of the timer.
module tb_counterup16_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, hold, periodic, irq_clr;
    logic [15:0] period;
    logic [15:0] count;
    logic        tick, irq, busy;
    logic [1:0]  state;
`ifdef COUNTERUP16_SCHED_PRESCALE_EN
    logic [7:0]  prescale;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: progress expressed as advance counts and modulo arithmetic.
    int     m_state;
    longint m_count, m_period, m_steps, m_cycles;
    bit     m_periodic, m_tick, m_irq;

    counterup16_sched dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .periodic (periodic),
        .period   (period),
        .irq_clr  (irq_clr),
`ifdef COUNTERUP16_SCHED_PRESCALE_EN
        .prescale (prescale),
`endif
        .count    (count),
        .tick     (tick),
        .irq      (irq),
        .busy     (busy),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic longint pscDiv();
`ifdef COUNTERUP16_SCHED_PRESCALE_EN
        return longint'(prescale) + 1;
`else
        return 1;
`endif
    endfunction

    task automatic modelReset();
        m_state = 0; m_count = 0; m_period = 0; m_periodic = 0;
        m_tick = 0; m_irq = 0; m_steps = 0; m_cycles = 0;
    endtask

    task automatic modelStep();
        bit nt;
        nt = 0;
        if (stop) begin
            m_state = 0;
        end else if (start) begin
            m_period = period; m_periodic = periodic;
            m_count = 0; m_steps = 0; m_cycles = 0; m_state = 1;
        end else if (m_state == 1) begin
            if (hold) begin
                m_state = 2;
            end else begin
                m_cycles++;
                if (m_cycles % pscDiv() == 0) begin
                    m_steps++;
                    if (m_periodic) begin
                        m_count = m_steps % (m_period + 1);
                        nt = (m_count == 0);
                    end else if (m_steps > m_period) begin
                        nt = 1; m_count = m_period; m_state = 3;
                    end else begin
                        m_count = m_steps;
                    end
                end
            end
        end else if (m_state == 2 && !hold) begin
            m_state = 1;
        end
        m_tick = nt;
        m_irq  = nt ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
    endtask

    task automatic checkAll();
        checkOutput("count", count, m_count);
        checkOutput("tick", tick, m_tick);
        checkOutput("irq", irq, m_irq);
        checkOutput("state", state, m_state);
        checkOutput("busy", busy, (m_state == 1 || m_state == 2));
    endtask

    // Drives one cycle of inputs, advances the model at the edge, checks 1ns later.
    task automatic applyStimulus(input bit st, input bit sp, input bit hd, input bit pm,
                                 input logic [15:0] per, input bit clr);
        start = st; stop = sp; hold = hd; periodic = pm; period = per; irq_clr = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, periodic, period, 0);
    endtask

    int ticks_seen;
    int first_tick;

    initial begin
        reset = 1'b0; start = 0; stop = 0; hold = 0; periodic = 0; irq_clr = 0; period = '0;
`ifdef COUNTERUP16_SCHED_PRESCALE_EN
        prescale = '0;
`endif
        modelReset();
        #12;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_irq", irq, 0);
        checkOutput("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset in the middle of a run
        $display("[TB] reset mid-run");
        applyStimulus(1, 0, 0, 0, 16'd9, 0);
        idle(5);
        checkOutput("pre_rst_count", count, 5);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_count", count, 0);
        checkOutput("async_rst_state", state, 0);
        checkOutput("async_rst_irq", irq, 0);
        @(negedge clk);
        reset = 1'b1;

        // One-shot period 3
        $display("[TB] one-shot");
        applyStimulus(1, 0, 0, 0, 16'd3, 0);
        ticks_seen = 0; first_tick = -1;
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 0, 0, 0, 16'd3, 0);
            if (tick) begin ticks_seen++; if (first_tick < 0) first_tick = i; end
        end
        checkOutput("oneshot_ticks", ticks_seen, 1);
        checkOutput("oneshot_first", first_tick, 4);
        checkOutput("oneshot_done", state, 3);
        checkOutput("oneshot_hold", count, 3);
        applyStimulus(0, 0, 0, 0, 16'd3, 1);
        checkOutput("irq_cleared", irq, 0);

        // Periodic period 2, irq_clr collides with a tick
        $display("[TB] periodic");
        applyStimulus(1, 0, 0, 1, 16'd2, 0);
        idle(2);
        applyStimulus(0, 0, 0, 1, 16'd2, 1);
        checkOutput("tick_on_e3", tick, 1);
        checkOutput("irq_set_wins", irq, 1);
        ticks_seen = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 1, 16'd2, 0);
            if (tick) ticks_seen++;
        end
        checkOutput("periodic_ticks", ticks_seen, 3);

        // Pause for 4 edges at count 2 with period 5
        $display("[TB] pause");
        applyStimulus(0, 1, 0, 0, 16'd5, 1);
        applyStimulus(1, 0, 0, 0, 16'd5, 0);
        first_tick = -1;
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(0, 0, (i >= 3 && i <= 6), 0, 16'd5, 0);
            if (i == 4) begin
                checkOutput("pause_state", state, 2);
                checkOutput("pause_count", count, 2);
            end
            if (tick && first_tick < 0) first_tick = i;
        end
        checkOutput("pause_delay", first_tick, 11);

        // stop+start together, restart mid-run, period change mid-run
        $display("[TB] command collisions");
        applyStimulus(1, 0, 0, 0, 16'd7, 0);
        idle(4);
        checkOutput("restart_pre", count, 4);
        applyStimulus(1, 0, 0, 0, 16'd2, 0);
        checkOutput("restart_count", count, 0);
        applyStimulus(0, 0, 0, 0, 16'd100, 0);
        applyStimulus(0, 0, 0, 0, 16'd100, 0);
        applyStimulus(0, 0, 0, 0, 16'd100, 0);
        checkOutput("new_period_tick", tick, 1);
        applyStimulus(1, 0, 0, 1, 16'd9, 0);
        idle(3);
        applyStimulus(1, 1, 0, 1, 16'd9, 0);
        checkOutput("stopstart_state", state, 0);
        checkOutput("stopstart_count", count, 3);

`ifdef COUNTERUP16_SCHED_PRESCALE_EN
        $display("[TB] prescale");
        prescale = 8'd2;
        applyStimulus(1, 0, 0, 1, 16'd1, 0);
        ticks_seen = 0; first_tick = -1;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(0, 0, 0, 1, 16'd1, 0);
            if (i == 3) checkOutput("psc_first_advance", count, 1);
            if (tick) begin ticks_seen++; if (first_tick < 0) first_tick = i; end
        end
        checkOutput("psc_first_tick", first_tick, 6);
        checkOutput("psc_ticks", ticks_seen, 2);
        applyStimulus(0, 1, 0, 1, 16'd1, 0);
        prescale = 8'd1;
`endif

        // Randomized command mix against the model
        $display("[TB] random");
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] per;
            per = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            applyStimulus($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 15, $urandom_range(0, 1) == 1,
                          per, $urandom_range(0, 99) < 10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
